// File: rtl/console_mux_pkg.sv
// Shared types and constants for the console multiplexer / UART TX scheduler.
package console_mux_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACK,
    ST_SEND_TAG,
    ST_WAIT_TAG,
    ST_SEND_DATA,
    ST_WAIT_DATA
  } sched_state_e;

  // Tag byte for source 0; source i is tagged TAG_BASE_DEFAULT + i.
  localparam logic [7:0] TAG_BASE_DEFAULT = 8'hF0;

  // Width of a source index; never below one bit so a lone source still has a field.
  function automatic int SRC_IDX_W(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr, wrapping.
module rr_arbiter
  import console_mux_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = SRC_IDX_W(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_vld
);

  // Walk the requests starting at ptr; the first hit wins.
  always_comb begin
    int          cand;
    logic [IW-1:0] cidx;
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    cand    = 0;
    cidx    = '0;
    for (int off = 0; off < N; off++) begin
      cand = int'(ptr) + off;
      if (cand >= N) begin
        cand = cand - N;
      end
      cidx = IW'(cand);
      if (!gnt_vld && req[cidx]) begin
        gnt_vld   = 1'b1;
        gnt_idx   = cidx;
        gnt[cidx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one 8N1 UART transmitter among N_SRC console
// sources, inserting a channel tag byte whenever the serviced source changes.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | no frame in flight; arbitrate over src_valid
// ST_ACK       | src_ready pulse to the granted source
// ST_SEND_TAG  | tx_start pulse carrying TAG_BASE + grant
// ST_WAIT_TAG  | waiting for tx_done of the tag frame (watchdog running)
// ST_SEND_DATA | tx_start pulse carrying the latched byte
// ST_WAIT_DATA | waiting for tx_done of the data frame (watchdog running)
module uart_tx_sched
  import console_mux_pkg::*;
#(
  parameter int                N_SRC    = 4,
  parameter int                DATA_W   = 8,
  parameter bit                TAG_EN   = 1'b1,
  parameter logic [DATA_W-1:0] TAG_BASE = DATA_W'(TAG_BASE_DEFAULT),
  parameter int                TIMEOUT  = 4096
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_SRC-1:0]          src_valid,
  input  logic [N_SRC*DATA_W-1:0]   src_data,
  output logic [N_SRC-1:0]          src_ready,
  output logic [DATA_W-1:0]         tx_data,
  output logic                      tx_start,
  input  logic                      tx_done,
  output logic                      busy,
  output logic [$clog2(N_SRC)-1:0]  grant_idx,
  output logic                      timeout_err
);

  localparam int IDX_W = SRC_IDX_W(N_SRC);
  localparam int WD_W  = $clog2(TIMEOUT);
  // The watchdog fires on the cycle it would step onto TIMEOUT-1, so the
  // timeout_err pulse lands TIMEOUT cycles after the tx_start pulse.
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 2);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_SRC - 1);

  sched_state_e state_q, state_d;

  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]  last_src_q, last_src_d;
  logic              last_vld_q, last_vld_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;
  logic [DATA_W-1:0] byte_q, byte_d;
  logic [IDX_W-1:0]  grant_idx_q, grant_idx_d;
  logic [N_SRC-1:0]  src_ready_q, src_ready_d;
  logic              tx_start_q, tx_start_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              busy_q, busy_d;
  logic              timeout_err_q, timeout_err_d;

  logic [N_SRC-1:0]  arb_gnt;
  logic [IDX_W-1:0]  arb_idx;
  logic              arb_vld;
  logic [DATA_W-1:0] arb_data;
  logic [DATA_W-1:0] tag_byte;
  logic              need_tag;
  logic              wdog_expired;

  rr_arbiter #(
    .N (N_SRC)
  ) u_rr_arbiter (
    .req     (src_valid),
    .ptr     (rr_ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .gnt_vld (arb_vld)
  );

  // Winning byte, tag for the serviced source, tag decision and watchdog limit.
  assign arb_data     = src_data[arb_idx*DATA_W +: DATA_W];
  assign tag_byte     = TAG_BASE + DATA_W'(grant_idx_q);
  assign need_tag     = TAG_EN && (!last_vld_q || (last_src_q != grant_idx_q));
  assign wdog_expired = (wdog_q == WD_LAST);

  // Next state and next registered outputs; pulses default low every cycle.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    last_src_d    = last_src_q;
    last_vld_d    = last_vld_q;
    wdog_d        = wdog_q;
    byte_d        = byte_q;
    grant_idx_d   = grant_idx_q;
    tx_data_d     = tx_data_q;
    src_ready_d   = '0;
    tx_start_d    = 1'b0;
    timeout_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (arb_vld) begin
          byte_d      = arb_data;
          grant_idx_d = arb_idx;
          rr_ptr_d    = (arb_idx == IDX_LAST) ? '0 : arb_idx + IDX_W'(1);
          src_ready_d = arb_gnt;
          state_d     = ST_ACK;
        end
      end

      ST_ACK: begin
        tx_start_d = 1'b1;
        if (need_tag) begin
          tx_data_d = tag_byte;
          state_d   = ST_SEND_TAG;
        end else begin
          tx_data_d = byte_q;
          state_d   = ST_SEND_DATA;
        end
      end

      ST_SEND_TAG: begin
        wdog_d  = '0;
        state_d = ST_WAIT_TAG;
      end

      ST_WAIT_TAG: begin
        if (tx_done) begin
          tx_start_d = 1'b1;
          tx_data_d  = byte_q;
          state_d    = ST_SEND_DATA;
        end else if (wdog_expired) begin
          timeout_err_d = 1'b1;
          last_vld_d    = 1'b0;
          state_d       = ST_IDLE;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end

      ST_SEND_DATA: begin
        wdog_d  = '0;
        state_d = ST_WAIT_DATA;
      end

      ST_WAIT_DATA: begin
        if (tx_done) begin
          last_src_d = grant_idx_q;
          last_vld_d = 1'b1;
          state_d    = ST_IDLE;
        end else if (wdog_expired) begin
          timeout_err_d = 1'b1;
          last_vld_d    = 1'b0;
          state_d       = ST_IDLE;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath, bookkeeping and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q      <= '0;
      last_src_q    <= '0;
      last_vld_q    <= 1'b0;
      wdog_q        <= '0;
      byte_q        <= '0;
      grant_idx_q   <= '0;
      src_ready_q   <= '0;
      tx_start_q    <= 1'b0;
      tx_data_q     <= '0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      last_src_q    <= last_src_d;
      last_vld_q    <= last_vld_d;
      wdog_q        <= wdog_d;
      byte_q        <= byte_d;
      grant_idx_q   <= grant_idx_d;
      src_ready_q   <= src_ready_d;
      tx_start_q    <= tx_start_d;
      tx_data_q     <= tx_data_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign src_ready   = src_ready_q;
  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign busy        = busy_q;
  assign grant_idx   = grant_idx_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: an action-list reference model of one service
// (ready, optional tag frame, data frame) checked against the DUT every cycle,
// plus directed scenarios with hand-computed expectations and a TAG_EN=0 copy.
module tb_uart_tx_sched;

  localparam int N   = 4;
  localparam int TMO = 16;

  localparam int P_READY = 0;
  localparam int P_TAG   = 1;
  localparam int P_DATA  = 2;
  localparam int P_GAP   = 3;
  localparam int P_WAIT  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic [N-1:0]   src_valid;
  logic [N*8-1:0] src_data;
  logic [N-1:0]   src_ready;
  logic [7:0]     tx_data;
  logic           tx_start;
  logic           tx_done;
  logic           busy;
  logic [1:0]     grant_idx;
  logic           timeout_err;

  logic           rst2_n;
  logic [N-1:0]   src2_valid;
  logic [N*8-1:0] src2_data;
  logic [N-1:0]   src2_ready;
  logic [7:0]     tx2_data;
  logic           tx2_start;
  logic           tx2_done;
  logic           busy2;
  logic [1:0]     gidx2;
  logic           terr2;

  uart_tx_sched #(.N_SRC(N), .DATA_W(8), .TAG_EN(1'b1), .TAG_BASE(8'hF0), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .src_valid(src_valid), .src_data(src_data),
    .src_ready(src_ready), .tx_data(tx_data), .tx_start(tx_start), .tx_done(tx_done),
    .busy(busy), .grant_idx(grant_idx), .timeout_err(timeout_err));

  uart_tx_sched #(.N_SRC(N), .DATA_W(8), .TAG_EN(1'b0), .TAG_BASE(8'hF0), .TIMEOUT(4096)) dut2 (
    .clk(clk), .rst_n(rst2_n), .src_valid(src2_valid), .src_data(src2_data),
    .src_ready(src2_ready), .tx_data(tx2_data), .tx_start(tx2_start), .tx_done(tx2_done),
    .busy(busy2), .grant_idx(gidx2), .timeout_err(terr2));

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // sources: per-source byte queues; the head is what is being offered
  logic [7:0] srcq  [N][$];
  logic [7:0] src2q [N][$];

  // transmitter stand-ins
  int resp_cnt  = 0;
  int resp2_cnt = 0;
  int fix_delay = 5;
  bit rand_tx   = 1'b0;
  bit withhold  = 1'b0;

  // event logs
  logic [7:0] start_log [$];
  int         start_cyc [$];
  logic [7:0] start2_log [$];
  int         ready_cnt [N];
  int         ready_cyc [N];
  int         terr_cyc;
  bit         terr_seen;

  // reference model
  int         m_plan [$];
  int         m_g, m_last, m_ptr, m_cnt;
  logic [7:0] m_byte;
  logic [3:0] e_ready;
  logic       e_start, e_busy, e_terr, e_rst;
  logic [7:0] e_data;
  logic [1:0] e_gidx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One edge of the model: what must be visible just after this rising edge.
  task automatic model_step();
    bit cont;
    e_ready = '0;
    e_start = 1'b0;
    e_terr  = 1'b0;
    e_rst   = 1'b0;
    if (!rst_n) begin
      m_plan.delete();
      m_last = -1;
      m_ptr  = 0;
      m_cnt  = 0;
      e_gidx = '0;
      e_data = '0;
      e_busy = 1'b0;
      e_rst  = 1'b1;
      return;
    end
    if (m_plan.size() == 0 && src_valid != '0) begin
      m_g = -1;
      for (int off = 0; off < N; off++) begin
        if (m_g < 0 && src_valid[(m_ptr + off) % N]) m_g = (m_ptr + off) % N;
      end
      m_byte = src_data[m_g*8 +: 8];
      m_ptr  = (m_g + 1) % N;
      e_gidx = 2'(m_g);
      m_plan.push_back(P_READY);
      if (m_g != m_last) begin
        m_plan.push_back(P_TAG);
        m_plan.push_back(P_GAP);
        m_plan.push_back(P_WAIT);
      end
      m_plan.push_back(P_DATA);
      m_plan.push_back(P_GAP);
      m_plan.push_back(P_WAIT);
    end
    cont = 1'b1;
    while (cont && m_plan.size() > 0) begin
      cont = 1'b0;
      case (m_plan[0])
        P_READY: begin
          e_ready = 4'(1 << m_g);
          void'(m_plan.pop_front());
        end
        P_TAG: begin
          e_start = 1'b1;
          e_data  = 8'hF0 + 8'(m_g);
          void'(m_plan.pop_front());
        end
        P_DATA: begin
          e_start = 1'b1;
          e_data  = m_byte;
          void'(m_plan.pop_front());
        end
        P_GAP: begin
          m_cnt = 0;
          void'(m_plan.pop_front());
        end
        default: begin
          if (tx_done) begin
            void'(m_plan.pop_front());
            if (m_plan.size() == 0) m_last = m_g;
            else cont = 1'b1;
          end else begin
            m_cnt++;
            if (m_cnt == TMO - 1) begin
              e_terr = 1'b1;
              m_last = -1;
              m_plan.delete();
            end
          end
        end
      endcase
    end
    e_busy = (m_plan.size() != 0);
  endtask

  task automatic present();
    for (int i = 0; i < N; i++) begin
      src_valid[i]      = (srcq[i].size() > 0);
      src_data[i*8 +: 8] = (srcq[i].size() > 0) ? srcq[i][0] : 8'h00;
      src2_valid[i]      = (src2q[i].size() > 0);
      src2_data[i*8 +: 8] = (src2q[i].size() > 0) ? src2q[i][0] : 8'h00;
    end
  endtask

  function automatic bit model_idle();
    bit r;
    r = (m_plan.size() == 0);
    for (int i = 0; i < N; i++) if (srcq[i].size() != 0) r = 1'b0;
    return r;
  endfunction

  task automatic clear_logs();
    start_log.delete();
    start_cyc.delete();
    start2_log.delete();
    terr_seen = 1'b0;
    terr_cyc  = 0;
    for (int i = 0; i < N; i++) begin
      ready_cnt[i] = 0;
      ready_cyc[i] = -1;
    end
  endtask

  // One clock: model, compare, log, then drive the transmitter and sources.
  task automatic tick();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
    chk("src_ready", 32'(src_ready), 32'(e_ready));
    chk("tx_start", 32'(tx_start), 32'(e_start));
    if (e_start || e_rst) chk("tx_data", 32'(tx_data), 32'(e_data));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("grant_idx", 32'(grant_idx), 32'(e_gidx));
    chk("timeout_err", 32'(timeout_err), 32'(e_terr));

    if (tx_start) begin
      start_log.push_back(tx_data);
      start_cyc.push_back(cyc);
    end
    if (timeout_err) begin
      terr_seen = 1'b1;
      terr_cyc  = cyc;
    end
    if (tx2_start) start2_log.push_back(tx2_data);

    tx_done = 1'b0;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) tx_done = 1'b1;
    end
    if (tx_start) begin
      if (rand_tx) resp_cnt = ($urandom_range(99) < 8) ? 0 : int'($urandom_range(14, 1));
      else resp_cnt = withhold ? 0 : fix_delay;
    end else if (rand_tx && resp_cnt == 0 && !tx_done && $urandom_range(99) < 2) begin
      tx_done = 1'b1;
    end

    tx2_done = 1'b0;
    if (resp2_cnt > 0) begin
      resp2_cnt--;
      if (resp2_cnt == 0) tx2_done = 1'b1;
    end
    if (tx2_start) resp2_cnt = 3;

    for (int i = 0; i < N; i++) begin
      if (src_ready[i]) begin
        ready_cnt[i]++;
        if (ready_cyc[i] < 0) ready_cyc[i] = cyc;
        if (srcq[i].size() > 0) void'(srcq[i].pop_front());
      end
      if (src2_ready[i] && src2q[i].size() > 0) void'(src2q[i].pop_front());
    end
    present();
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (!model_idle() && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (!model_idle()) begin
      errors++;
      $display("FAIL %s: still busy after %0d cycles, required idle", name, budget);
    end
  endtask

  initial begin
    int k;
    rst_n = 1'b0; rst2_n = 1'b0;
    src_valid = '0; src_data = '0; src2_valid = '0; src2_data = '0;
    tx_done = 1'b0; tx2_done = 1'b0;
    clear_logs();

    // reset state, then single source 2 from reset
    repeat (3) tick();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_tx_data", 32'(tx_data), 32'd0);
    rst_n = 1'b1;
    tick();
    srcq[2].push_back(8'h41);
    present();
    k = cyc;
    wait_idle("single_src", 200);
    chk("single_nstarts", 32'(start_log.size()), 32'd2);
    if (start_log.size() == 2) begin
      chk("single_tag", 32'(start_log[0]), 32'hF2);
      chk("single_data", 32'(start_log[1]), 32'h41);
      chk("single_tag_lat", 32'(start_cyc[0]), 32'(k + 2));
    end
    chk("single_ready_cnt", 32'(ready_cnt[2]), 32'd1);
    chk("single_ready_lat", 32'(ready_cyc[2]), 32'(k + 1));

    // same source again: no tag, two-cycle latency
    clear_logs();
    srcq[2].push_back(8'h42);
    present();
    k = cyc;
    wait_idle("repeat_src", 200);
    chk("repeat_nstarts", 32'(start_log.size()), 32'd1);
    if (start_log.size() == 1) begin
      chk("repeat_data", 32'(start_log[0]), 32'h42);
      chk("repeat_lat", 32'(start_cyc[0]), 32'(k + 2));
    end

    // contention from a fresh pointer
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    clear_logs();
    for (int i = 0; i < N; i++) srcq[i].push_back(8'h10 + 8'(i));
    present();
    wait_idle("contention", 400);
    chk("cont_nstarts", 32'(start_log.size()), 32'd8);
    if (start_log.size() == 8) begin
      logic [7:0] exp_seq [8];
      exp_seq = '{8'hF0, 8'h10, 8'hF1, 8'h11, 8'hF2, 8'h12, 8'hF3, 8'h13};
      for (int i = 0; i < 8; i++) chk($sformatf("cont_byte%0d", i), 32'(start_log[i]), 32'(exp_seq[i]));
    end
    for (int i = 0; i < N; i++) chk($sformatf("cont_ready%0d", i), 32'(ready_cnt[i]), 32'd1);

    // timeout after a tag, then the same source is tagged again
    clear_logs();
    withhold = 1'b1;
    srcq[1].push_back(8'h33);
    present();
    k = 0;
    while (!terr_seen && k < 100) begin
      tick();
      k++;
    end
    chk("timeout_seen", 32'(terr_seen), 32'd1);
    if (start_log.size() >= 1) begin
      chk("timeout_tag", 32'(start_log[0]), 32'hF1);
      chk("timeout_delay", 32'(terr_cyc - start_cyc[0]), 32'd16);
    end
    chk("timeout_nstarts", 32'(start_log.size()), 32'd1);
    withhold = 1'b0;
    tick();
    srcq[1].push_back(8'h34);
    present();
    wait_idle("after_timeout", 200);
    chk("retag_nstarts", 32'(start_log.size()), 32'd3);
    if (start_log.size() == 3) begin
      chk("retag_tag", 32'(start_log[1]), 32'hF1);
      chk("retag_data", 32'(start_log[2]), 32'h34);
    end

    // reset during the data frame wait
    clear_logs();
    fix_delay = 10;
    srcq[2].push_back(8'h77);
    present();
    k = 0;
    while (start_log.size() < 2 && k < 100) begin
      tick();
      k++;
    end
    chk("midrst_reached", 32'(start_log.size()), 32'd2);
    tick();
    rst_n = 1'b0;
    resp_cnt = 0;
    tick();
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_start", 32'(tx_start), 32'd0);
    chk("midrst_gidx", 32'(grant_idx), 32'd0);
    rst_n = 1'b1;
    fix_delay = 5;
    clear_logs();
    srcq[3].push_back(8'h01);
    srcq[0].push_back(8'h02);
    present();
    wait_idle("after_midrst", 300);
    chk("midrst_nstarts", 32'(start_log.size()), 32'd4);
    if (start_log.size() == 4) begin
      chk("midrst_b0", 32'(start_log[0]), 32'hF0);
      chk("midrst_b1", 32'(start_log[1]), 32'h02);
      chk("midrst_b2", 32'(start_log[2]), 32'hF3);
      chk("midrst_b3", 32'(start_log[3]), 32'h01);
    end

    // TAG_EN = 0 copy: sources 1 then 3
    rst2_n = 1'b1;
    tick();
    clear_logs();
    src2q[1].push_back(8'h55);
    src2q[3].push_back(8'hAA);
    present();
    k = 0;
    while ((start2_log.size() < 2 || busy2) && k < 200) begin
      tick();
      k++;
    end
    repeat (5) tick();
    chk("notag_nstarts", 32'(start2_log.size()), 32'd2);
    if (start2_log.size() == 2) begin
      chk("notag_b0", 32'(start2_log[0]), 32'h55);
      chk("notag_b1", 32'(start2_log[1]), 32'hAA);
    end
    chk("notag_gidx", 32'(gidx2), 32'd3);
    chk("notag_terr", 32'(terr2), 32'd0);

    // randomized traffic against the model
    rand_tx = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      tick();
      rst_n = ($urandom_range(999) < 2) ? 1'b0 : 1'b1;
      for (int i = 0; i < N; i++) begin
        if (srcq[i].size() < 3 && $urandom_range(99) < 15) srcq[i].push_back(8'($urandom_range(255)));
      end
      present();
    end
    rst_n = 1'b1;
    rand_tx = 1'b0;
    fix_delay = 4;
    wait_idle("drain", 2000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
